tl_ul_slave_responder: RTL and testbench

- Single-beat TileLink-UL slave model with a word-addressed backing store.
- Accepts A-channel requests, performs the access, and returns D-channel responses after a fixed latency.
- Its A/D channel pins drive the TileLink monitor assert wrapper directly. It is the device-side stage feeding the protocol monitor in the eval bench.
- Responses are returned strictly in order through a small response queue.

---
 rtl/tl_ul_pkg.sv | 31 +++
 rtl/tl_ul_resp_fifo.sv | 62 ++++++
 rtl/tl_ul_slave_responder.sv | 147 ++++++++++++++
 tb/tb_tl_ul_slave_responder.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcodes and the response-queue entry layout used by
// tl_ul_slave_responder and its response FIFO.
package tl_ul_pkg;

  localparam logic [2:0] A_PUTFULL    = 3'd0;
  localparam logic [2:0] A_PUTPARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH      = 3'd2;
  localparam logic [2:0] A_LOGIC      = 3'd3;
  localparam logic [2:0] A_GET        = 3'd4;
  localparam logic [2:0] A_INTENT     = 3'd5;

  localparam logic [2:0] D_ACK        = 3'd0;
  localparam logic [2:0] D_ACKDATA    = 3'd1;
  localparam logic [2:0] D_HINTACK    = 3'd2;

  // Entry widths follow the responder's default SRC_W/DATA_W.
  localparam int TL_SRC_W  = 4;
  localparam int TL_DATA_W = 32;
  localparam int CNT_W     = 8;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [3:0]           size;
    logic [TL_SRC_W-1:0]  source;
    logic                 denied;
    logic                 corrupt;
    logic [TL_DATA_W-1:0] data;
    logic [CNT_W-1:0]     cnt;
  } resp_entry_t;

endpackage

// File: rtl/tl_ul_resp_fifo.sv
// In-order response queue; every entry carries a latency countdown that is
// loaded on enqueue and decremented each cycle until it saturates at zero.
module tl_ul_resp_fifo
  import tl_ul_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output resp_entry_t head,
  output logic        head_ready,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  resp_entry_t entries [DEPTH];
  resp_entry_t load_entry;

  always_comb begin
    load_entry     = push_entry;
    load_entry.cnt = CNT_W'(LATENCY - 1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Free slots keep counting down too; they are overwritten on their next push.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr[AW-1:0] == AW'(i)))
          entries[i] <= load_entry;
        else if (entries[i].cnt != '0)
          entries[i].cnt <= entries[i].cnt - CNT_W'(1);
      end
    end
  end

  assign head       = entries[rd_ptr[AW-1:0]];
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count      = wr_ptr - rd_ptr;
  assign head_ready = !empty && (head.cnt == '0);

endmodule

// File: rtl/tl_ul_slave_responder.sv
// Single-beat TileLink-UL slave: decodes A requests against a word store and
// returns in-order D responses. TL_UL_SLAVE_RESPONDER_BACKPRESSURE_EN adds LFSR-driven a_ready throttling.
module tl_ul_slave_responder
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = TL_DATA_W,
  parameter int SRC_W     = TL_SRC_W,
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 64,
  parameter int LATENCY   = 2,
  localparam int QW       = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [3:0]          a_size,
  input  logic [SRC_W-1:0]    a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_mask,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [3:0]          d_size,
  output logic [SRC_W-1:0]    d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [DATA_W-1:0]   d_data,
  output logic                d_corrupt,
  output logic [QW-1:0]       outstanding
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int MEM_AW = $clog2(MEM_WORDS);

  logic              accept;
  logic              full;
  logic              empty;
  logic              head_ready;
  logic              legal;
  logic              do_write;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] align_mask;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] store [MEM_WORDS];
  resp_entry_t       new_entry;
  resp_entry_t       head;
  logic              unused_bits;

`ifdef TL_UL_SLAVE_RESPONDER_BACKPRESSURE_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign a_ready = !full && lfsr[0];
`else
  assign a_ready = !full;
`endif

  assign accept     = a_valid && a_ready;
  assign word_idx   = a_address >> LANE_W;
  assign align_mask = (ADDR_W'(1) << a_size) - ADDR_W'(1);
  assign legal      = (word_idx < ADDR_W'(MEM_WORDS)) && (a_size <= 4'(LANE_W))
                   && ((a_address & align_mask) == '0);
  assign rd_word    = store[word_idx[MEM_AW-1:0]];

  // Response is built from the request as seen at the accepting edge.
  always_comb begin
    new_entry        = '0;
    new_entry.size   = a_size;
    new_entry.source = a_source;
    do_write         = 1'b0;
    case (a_opcode)
      A_PUTFULL, A_PUTPARTIAL: begin
        new_entry.opcode = D_ACK;
        new_entry.denied = !(legal && !a_corrupt);
        do_write         = accept && legal && !a_corrupt;
      end
      A_GET: begin
        new_entry.opcode = D_ACKDATA;
        if (legal) begin
          new_entry.data = rd_word;
        end else begin
          new_entry.denied  = 1'b1;
          new_entry.corrupt = 1'b1;
        end
      end
      A_INTENT: new_entry.opcode = D_HINTACK;
      A_ARITH, A_LOGIC: begin
        new_entry.opcode  = D_ACKDATA;
        new_entry.denied  = 1'b1;
        new_entry.corrupt = 1'b1;
      end
      default: begin
        new_entry.opcode = D_ACK;
        new_entry.denied = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) store[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < LANES; b++)
        if (a_mask[b]) store[word_idx[MEM_AW-1:0]][b*8 +: 8] <= a_data[b*8 +: 8];
    end
  end

  tl_ul_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (accept),
    .push_entry (new_entry),
    .pop        (head_ready && d_ready),
    .head       (head),
    .head_ready (head_ready),
    .full       (full),
    .empty      (empty),
    .count      (outstanding)
  );

  assign d_valid     = head_ready;
  assign d_opcode    = head.opcode;
  assign d_param     = 2'b00;
  assign d_size      = head.size;
  assign d_source    = head.source;
  assign d_sink      = 1'b0;
  assign d_denied    = head.denied;
  assign d_corrupt   = head.corrupt;
  assign d_data      = head.data;
  assign unused_bits = ^{a_param, head.cnt, empty};

endmodule

// File: tb/tb_tl_ul_slave_responder.sv
// Self-checking bench for tl_ul_slave_responder: directed vector table, hand-written
// latency/full/reset sequences, and a randomized run against a queue-based reference model.
module tb_tl_ul_slave_responder;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic        clock;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [3:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [3:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;
  logic [2:0]  outstanding;

  tl_ul_slave_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_opcode    (a_opcode),
    .a_param     (a_param),
    .a_size      (a_size),
    .a_source    (a_source),
    .a_address   (a_address),
    .a_mask      (a_mask),
    .a_data      (a_data),
    .a_corrupt   (a_corrupt),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_opcode    (d_opcode),
    .d_param     (d_param),
    .d_size      (d_size),
    .d_source    (d_source),
    .d_sink      (d_sink),
    .d_denied    (d_denied),
    .d_data      (d_data),
    .d_corrupt   (d_corrupt),
    .outstanding (outstanding)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [3:0]  source;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
    int          acc_edge;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [31:0] e_data;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        pend_entry;
  logic [3:0]  seen_q[$];
  logic [31:0] ref_mem[64];
  bit          acc_pending;
  bit          deq_pending;
  bit          rand_ready;
  int          edge_cnt;
  int          vectors;
  int          miscompares;
  vec_t        vecs[16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the access rules; updates the model store.
  function automatic exp_t model_access(input logic [2:0] op, input logic [3:0] size,
                                        input logic [3:0] src, input logic [31:0] addr,
                                        input logic [3:0] mask, input logic [31:0] data,
                                        input logic corrupt);
    exp_t e;
    int   idx;
    bit   legal;
    e = '{opcode: 3'd0, size: size, source: src, denied: 1'b0, corrupt: 1'b0,
          data: 32'h0, acc_edge: 0};
    idx   = int'(addr[7:2]);
    legal = ((addr >> 2) < 32'd64) && (size <= 4'd2) && ((addr % (32'd1 << size)) == 32'd0);
    case (op)
      3'd0, 3'd1: begin
        e.opcode = 3'd0;
        if (legal && !corrupt) begin
          for (int b = 0; b < 4; b++)
            if (mask[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
          e.denied = 1'b1;
        end
      end
      3'd4: begin
        e.opcode = 3'd1;
        if (legal) e.data = ref_mem[idx];
        else begin e.denied = 1'b1; e.corrupt = 1'b1; end
      end
      3'd5: e.opcode = 3'd2;
      3'd2, 3'd3: begin e.opcode = 3'd1; e.denied = 1'b1; e.corrupt = 1'b1; end
      default: begin e.opcode = 3'd0; e.denied = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] size, input logic [3:0] src,
                               input logic [31:0] addr, input logic [3:0] mask,
                               input logic [31:0] data, input logic corrupt);
    bit done;
    done      = 1'b0;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_param   = 3'($urandom_range(0, 7));
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_corrupt = corrupt;
    for (int n = 0; n < 200 && !done; n++) begin
      if (a_ready) begin
        pend_entry  = model_access(op, size, src, addr, mask, data, corrupt);
        acc_pending = 1'b1;
        done        = 1'b1;
      end
      step();
    end
    a_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: got a_ready=0 for 200 cycles, expected acceptance");
    end
  endtask

  task automatic drain();
    d_ready = 1'b1;
    for (int n = 0; n < 100 && (outstanding != 3'd0); n++) step();
    checkOutput("drain_outstanding", outstanding, 0);
  endtask

  // Model bookkeeping mirrors the DUT's queue at each active edge.
  always @(posedge clock) begin
    edge_cnt++;
    if (!reset) begin
      if (deq_pending && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc_pending) begin
        pend_entry.acc_edge = edge_cnt;
        exp_q.push_back(pend_entry);
      end
    end
    acc_pending = 1'b0;
    deq_pending = 1'b0;
  end

  always @(negedge clock) begin
    if (!reset) begin
      bit ev;
      ev = (exp_q.size() > 0) && ((edge_cnt - exp_q[0].acc_edge) >= LATENCY - 1);
      checkOutput("d_valid", d_valid, ev);
      checkOutput("outstanding", outstanding, exp_q.size());
`ifndef TL_UL_SLAVE_RESPONDER_BACKPRESSURE_EN
      checkOutput("a_ready", a_ready, exp_q.size() < DEPTH);
`endif
      if (d_valid && ev) begin
        checkOutput("d_fields",
                    {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data},
                    {exp_q[0].opcode, 2'b00, exp_q[0].size, exp_q[0].source, 1'b0,
                     exp_q[0].denied, exp_q[0].corrupt, exp_q[0].data});
        if (d_ready) begin
          deq_pending = 1'b1;
          seen_q.push_back(d_source);
        end
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (rand_ready) d_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    edge_cnt    = 0;
    acc_pending = 1'b0;
    deq_pending = 1'b0;
    rand_ready  = 1'b0;
    reset       = 1'b0;
    a_valid     = 1'b0;
    a_opcode    = 3'd0;
    a_param     = 3'd0;
    a_size      = 4'd0;
    a_source    = 4'd0;
    a_address   = 32'h0;
    a_mask      = 4'h0;
    a_data      = 32'h0;
    a_corrupt   = 1'b0;
    d_ready     = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

    #1 reset = 1'b1;
    #1;
    checkOutput("reset_d_valid", d_valid, 0);
    checkOutput("reset_outstanding", outstanding, 0);
    checkOutput("reset_a_ready", a_ready, 1);
    checkOutput("reset_d_fields",
                {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    //                op     size  addr         mask  data          cor   e_op  den   cor   e_data
    vecs[0]  = '{3'd0, 4'd2, 32'h10,  4'hF, 32'hDEADBEEF, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{3'd4, 4'd2, 32'h10,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{3'd1, 4'd2, 32'h10,  4'h2, 32'h0000AA00, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{3'd4, 4'd2, 32'h10,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'hDEADAAEF};
    vecs[4]  = '{3'd4, 4'd2, 32'h100, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{3'd2, 4'd2, 32'h10,  4'hF, 32'h1,        1'b0, 3'd1, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{3'd3, 4'd2, 32'h10,  4'hF, 32'h1,        1'b0, 3'd1, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{3'd5, 4'd2, 32'h10,  4'hF, 32'h0,        1'b0, 3'd2, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{3'd4, 4'd2, 32'h12,  4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{3'd4, 4'd1, 32'h12,  4'hC, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'hDEADAAEF};
    vecs[10] = '{3'd4, 4'd3, 32'h10,  4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 1'b1, 32'h0};
    vecs[11] = '{3'd0, 4'd2, 32'h14,  4'hF, 32'h12345678, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{3'd4, 4'd2, 32'h14,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{3'd0, 4'd2, 32'h200, 4'hF, 32'h11111111, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{3'd0, 4'd2, 32'hFC,  4'hF, 32'hCAFEF00D, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{3'd4, 4'd2, 32'hFC,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 1'b0, 32'hCAFEF00D};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].size, 4'(i), vecs[i].addr, vecs[i].mask,
                    vecs[i].data, vecs[i].corrupt);
      for (int n = 0; n < 10 && !d_valid; n++) step();
      checkOutput($sformatf("vec%0d_valid", i), d_valid, 1);
      checkOutput($sformatf("vec%0d_resp", i),
                  {d_opcode, d_denied, d_corrupt, d_source, d_data},
                  {vecs[i].e_op, vecs[i].e_den, vecs[i].e_cor, 4'(i), vecs[i].e_data});
      step();
    end

    // Accept edge followed by exactly LATENCY-1 further edges before d_valid.
    applyStimulus(3'd4, 4'd2, 4'h7, 32'h10, 4'hF, 32'h0, 1'b0);
    checkOutput("lat_early", d_valid, 0);
    step();
    checkOutput("lat_ontime", d_valid, 1);
    checkOutput("lat_source", d_source, 4'h7);
    step();

    // Fill the queue with d_ready low, then release and check ordering.
    d_ready = 1'b0;
    seen_q.delete();
    for (int s = 0; s < 4; s++) applyStimulus(3'd4, 4'd2, 4'(s), 32'h10, 4'hF, 32'h0, 1'b0);
    checkOutput("full_a_ready", a_ready, 0);
    checkOutput("full_outstanding", outstanding, 4);
    step();
    step();
    checkOutput("full_a_ready_held", a_ready, 0);
    checkOutput("full_d_source_held", d_source, 0);
    d_ready = 1'b1;
    applyStimulus(3'd4, 4'd2, 4'd4, 32'h10, 4'hF, 32'h0, 1'b0);
    drain();
    checkOutput("order_count", seen_q.size(), 5);
    for (int s = 0; s < 5 && s < seen_q.size(); s++)
      checkOutput($sformatf("order_src%0d", s), seen_q[s], s);

    // Reset with responses queued drops them without waiting for an edge.
    applyStimulus(3'd0, 4'd2, 4'd8, 32'h20, 4'hF, 32'h55AA55AA, 1'b0);
    drain();
    d_ready = 1'b0;
    for (int s = 0; s < 3; s++) applyStimulus(3'd4, 4'd2, 4'(s), 32'h20, 4'hF, 32'h0, 1'b0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    acc_pending = 1'b0;
    deq_pending = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    #1;
    checkOutput("async_reset_d_valid", d_valid, 0);
    checkOutput("async_reset_outstanding", outstanding, 0);
    step();
    reset   = 1'b0;
    d_ready = 1'b1;
    applyStimulus(3'd4, 4'd2, 4'd9, 32'h20, 4'hF, 32'h0, 1'b0);
    for (int n = 0; n < 10 && !d_valid; n++) step();
    checkOutput("post_reset_valid", d_valid, 1);
    checkOutput("post_reset_data", d_data, 32'h0);
    step();

    // Randomized traffic with random D backpressure, checked by the monitor.
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic [2:0]  op;
      logic [3:0]  size;
      logic [31:0] addr;
      int          r;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2: op = 3'd0;
        3:       op = 3'd1;
        4, 5, 6: op = 3'd4;
        7:       op = 3'd2;
        8:       op = 3'd5;
        default: op = 3'd3;
      endcase
      size = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3)) : 4'd2;
      addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(60, 70)) << 2
                                         : 32'($urandom_range(0, 7)) << 2;
      if ($urandom_range(0, 4) == 0) addr = addr + 32'($urandom_range(1, 3));
      applyStimulus(op, size, 4'($urandom_range(0, 15)), addr, 4'($urandom_range(0, 15)),
                    $urandom, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 2) == 0) step();
    end
    rand_ready = 1'b0;
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
